// File: rtl/rf_pkg.sv
// Shared constants for the register-file writeback slice.
//   XLEN       : default data width of the register write port
//   NREG       : number of architectural integer registers
//   REG_ADDR_W : register index width
//   X0_IDX     : index of the hard-wired zero register
package rf_pkg;

    localparam int unsigned XLEN       = 32;
    localparam int unsigned NREG       = 32;
    localparam int unsigned REG_ADDR_W = 5;

    localparam logic [REG_ADDR_W-1:0] X0_IDX = '0;

endpackage

// File: rtl/wb_fifo.sv
// Synchronous FIFO holding load results waiting for a free register-file write slot.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   push_i     : write wdata_i (ignored when full)
//   wdata_i    : entry to enqueue
//   pop_i      : drop the head entry (ignored when empty)
//   rdata_o    : head entry (valid when !empty_o)
//   full_o     : count == DEPTH
//   empty_o    : count == 0
//   count_o    : number of stored entries, 0..DEPTH
module wb_fifo
    import rf_pkg::*;
#(
    parameter int unsigned WIDTH = REG_ADDR_W + XLEN,
    parameter int unsigned DEPTH = 2,
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int unsigned CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CNT_W-1:0] count_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             do_push, do_pop;

    assign full_o  = (cnt_q == CNT_W'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign count_o = cnt_q;
    assign rdata_o = mem_q[rd_ptr_q];

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_comb begin
        cnt_d = cnt_q;
        unique case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    // DEPTH is a power of two, so pointers wrap by natural overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            cnt_q <= cnt_d;
        end
    end

    // Storage needs no reset: entries are only observed while counted.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/rf_writeback.sv
// Register-file writeback arbiter with a pending-write scoreboard.
// ALU results (never back-pressured) take the single write port; load results are
// queued in wb_fifo and drain whenever the ALU leaves the port free.
// Ports:
//   clk, rst_n                 : clock, asynchronous active-low reset
//   alu_valid_i/rd_i/data_i    : ALU result, written one cycle later
//   ld_valid_i/rd_i/data_i     : load result offer; ld_ready_o = queue not full
//   issue_valid_i, issue_rd_i  : marks a destination register pending
//   WrEn_RF_o/WAddr_RF_o/WD_RF_o : registered register-file write port
//   pend_o                     : bit n set while a write to xn is outstanding
//   stall_req_o                : load queue full
module rf_writeback #(
    parameter int unsigned XLEN     = rf_pkg::XLEN,
    parameter int unsigned LQ_DEPTH = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          alu_valid_i,
    input  logic [rf_pkg::REG_ADDR_W-1:0] alu_rd_i,
    input  logic [XLEN-1:0]               alu_data_i,
    input  logic                          ld_valid_i,
    output logic                          ld_ready_o,
    input  logic [rf_pkg::REG_ADDR_W-1:0] ld_rd_i,
    input  logic [XLEN-1:0]               ld_data_i,
    input  logic                          issue_valid_i,
    input  logic [rf_pkg::REG_ADDR_W-1:0] issue_rd_i,
    output logic                          WrEn_RF_o,
    output logic [rf_pkg::REG_ADDR_W-1:0] WAddr_RF_o,
    output logic [XLEN-1:0]               WD_RF_o,
    output logic [rf_pkg::NREG-1:0]       pend_o,
    output logic                          stall_req_o
);

    import rf_pkg::*;

    localparam int unsigned ENT_W = REG_ADDR_W + XLEN;
    localparam int unsigned CNT_W = $clog2(LQ_DEPTH) + 1;

    logic                  alu_wr, ld_push, q_pop, q_full, q_empty;
    logic [ENT_W-1:0]      q_head;
    logic [CNT_W-1:0]      q_cnt;

    logic                  wr_en_d, wr_en_q;
    logic [REG_ADDR_W-1:0] waddr_d, waddr_q;
    logic [XLEN-1:0]       wdata_d, wdata_q;
    logic [NREG-1:0]       pend_d, pend_q, clr_mask, set_mask;

    assign alu_wr      = alu_valid_i && (alu_rd_i != X0_IDX);
    assign ld_ready_o  = !q_full;
    // x0 loads complete the handshake but never enter the queue.
    assign ld_push     = ld_valid_i && ld_ready_o && (ld_rd_i != X0_IDX);
    assign q_pop       = !alu_wr && !q_empty;
    assign stall_req_o = (q_cnt == CNT_W'(LQ_DEPTH));

    wb_fifo #(
        .WIDTH (ENT_W),
        .DEPTH (LQ_DEPTH)
    ) u_lq (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (ld_push),
        .wdata_i ({ld_rd_i, ld_data_i}),
        .pop_i   (q_pop),
        .rdata_o (q_head),
        .full_o  (q_full),
        .empty_o (q_empty),
        .count_o (q_cnt)
    );

    // Port select: ALU first, else queue head; address/data hold when idle.
    always_comb begin
        wr_en_d = 1'b0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        if (alu_wr) begin
            wr_en_d = 1'b1;
            waddr_d = alu_rd_i;
            wdata_d = alu_data_i;
        end else if (q_pop) begin
            wr_en_d = 1'b1;
            {waddr_d, wdata_d} = q_head;
        end
    end

    // Clear tracks the write currently on the port; a same-cycle issue re-sets it.
    always_comb begin
        clr_mask = wr_en_q ? (NREG'(1) << waddr_q) : '0;
        set_mask = issue_valid_i ? (NREG'(1) << issue_rd_i) : '0;
        pend_d   = ((pend_q & ~clr_mask) | set_mask) & ~NREG'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_en_q <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
            pend_q  <= '0;
        end else begin
            wr_en_q <= wr_en_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            pend_q  <= pend_d;
        end
    end

    assign WrEn_RF_o  = wr_en_q;
    assign WAddr_RF_o = waddr_q;
    assign WD_RF_o    = wdata_q;
    assign pend_o     = pend_q;

endmodule

// File: tb/tb_rf_writeback.sv
module tb_rf_writeback;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned DEPTH = 2;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            alu_valid = 1'b0;
    logic [4:0]      alu_rd = '0;
    logic [XLEN-1:0] alu_data = '0;
    logic            ld_valid = 1'b0;
    logic            ld_ready;
    logic [4:0]      ld_rd = '0;
    logic [XLEN-1:0] ld_data = '0;
    logic            issue_valid = 1'b0;
    logic [4:0]      issue_rd = '0;
    logic            wen;
    logic [4:0]      waddr;
    logic [XLEN-1:0] wd;
    logic [31:0]     pend;
    logic            stall;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    rf_writeback #(
        .XLEN     (XLEN),
        .LQ_DEPTH (DEPTH)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .alu_valid_i   (alu_valid),
        .alu_rd_i      (alu_rd),
        .alu_data_i    (alu_data),
        .ld_valid_i    (ld_valid),
        .ld_ready_o    (ld_ready),
        .ld_rd_i       (ld_rd),
        .ld_data_i     (ld_data),
        .issue_valid_i (issue_valid),
        .issue_rd_i    (issue_rd),
        .WrEn_RF_o     (wen),
        .WAddr_RF_o    (waddr),
        .WD_RF_o       (wd),
        .pend_o        (pend),
        .stall_req_o   (stall)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
        ld_valid = 1'b0; ld_rd = '0; ld_data = '0;
        issue_valid = 1'b0; issue_rd = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        logic        av; logic [4:0] ard; logic [31:0] adat;
        logic        lv; logic [4:0] lrd; logic [31:0] ldat;
        logic        iv; logic [4:0] ird;
        logic        e_rdy; logic e_stall;           // before the edge
        logic        e_wen; logic [4:0] e_addr; logic [31:0] e_wd; logic [31:0] e_pend;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic av, logic [4:0] ard, logic [31:0] adat,
                                logic lv, logic [4:0] lrd, logic [31:0] ldat,
                                logic iv, logic [4:0] ird, logic rdy, logic stl,
                                logic w, logic [4:0] a, logic [31:0] d, logic [31:0] p);
        vec_t v;
        v.av = av; v.ard = ard; v.adat = adat; v.lv = lv; v.lrd = lrd; v.ldat = ldat;
        v.iv = iv; v.ird = ird; v.e_rdy = rdy; v.e_stall = stl;
        v.e_wen = w; v.e_addr = a; v.e_wd = d; v.e_pend = p;
        return v;
    endfunction

    // ---------------- reference model ----------------
    typedef struct { logic [4:0] rd; logic [31:0] d; } ent_t;
    ent_t        mq[$];
    logic        m_wen;
    logic [4:0]  m_addr;
    logic [31:0] m_wd;
    logic [31:0] m_pend;

    task automatic model_reset();
        mq.delete();
        m_wen = 1'b0; m_addr = '0; m_wd = '0; m_pend = '0;
    endtask

    // One clock using the model; inputs must already be driven.
    task automatic model_step();
        ent_t        e;
        logic        accept;
        logic [31:0] np;
        chk("ld_ready", ld_ready, mq.size() < DEPTH);
        chk("stall_req", stall, mq.size() == DEPTH);
        accept = ld_valid && (mq.size() < DEPTH);
        np = m_pend;
        if (m_wen) np[m_addr] = 1'b0;
        if (issue_valid && issue_rd != 0) np[issue_rd] = 1'b1;
        m_pend = np;
        if (alu_valid && alu_rd != 0) begin
            m_wen = 1'b1; m_addr = alu_rd; m_wd = alu_data;
        end else if (mq.size() > 0) begin
            e = mq.pop_front();
            m_wen = 1'b1; m_addr = e.rd; m_wd = e.d;
        end else begin
            m_wen = 1'b0;
        end
        if (accept && ld_rd != 0) begin
            e.rd = ld_rd; e.d = ld_data;
            mq.push_back(e);
        end
        @(posedge clk);
        #1;
        chk("WrEn_RF", wen, m_wen);
        if (m_wen) begin
            chk("WAddr_RF", waddr, m_addr);
            chk("WD_RF", wd, m_wd);
        end
        chk("pend", pend, m_pend);
    endtask

    initial begin
        // Rows: inputs held for one cycle; ready/stall checked before the edge,
        // the write port and pend just after it.
        tbl.push_back(mk(0,0,0,          0,0,0,       1,5,  1,0, 0,0,0,          32'h20));
        tbl.push_back(mk(1,5,32'hDEADBEEF,0,0,0,      0,0,  1,0, 1,5,32'hDEADBEEF,32'h20));
        tbl.push_back(mk(0,0,0,          0,0,0,       0,0,  1,0, 0,5,32'hDEADBEEF,32'h0));
        tbl.push_back(mk(1,3,32'h33,     1,7,32'h77,  0,0,  1,0, 1,3,32'h33,       32'h0));
        tbl.push_back(mk(0,0,0,          0,0,0,       0,0,  1,0, 1,7,32'h77,       32'h0));
        tbl.push_back(mk(0,0,0,          0,0,0,       0,0,  1,0, 0,7,32'h77,       32'h0));
        tbl.push_back(mk(1,0,32'h11,     1,0,32'h22,  0,0,  1,0, 0,7,32'h77,       32'h0));
        tbl.push_back(mk(0,0,0,          0,0,0,       0,0,  1,0, 0,7,32'h77,       32'h0));
        tbl.push_back(mk(0,0,0,          0,0,0,       1,9,  1,0, 0,7,32'h77,       32'h200));
        tbl.push_back(mk(1,9,32'h99,     0,0,0,       0,0,  1,0, 1,9,32'h99,       32'h200));
        tbl.push_back(mk(0,0,0,          0,0,0,       1,9,  1,0, 0,9,32'h99,       32'h200));
        tbl.push_back(mk(1,4,32'h44,     1,10,32'hA0, 0,0,  1,0, 1,4,32'h44,       32'h200));
        tbl.push_back(mk(1,4,32'h45,     1,11,32'hB0, 0,0,  1,0, 1,4,32'h45,       32'h200));
        tbl.push_back(mk(1,4,32'h46,     1,12,32'hC0, 0,0,  0,1, 1,4,32'h46,       32'h200));
        tbl.push_back(mk(0,0,0,          0,0,0,       0,0,  0,1, 1,10,32'hA0,      32'h200));
        tbl.push_back(mk(0,0,0,          0,0,0,       0,0,  1,0, 1,11,32'hB0,      32'h200));
        tbl.push_back(mk(0,0,0,          0,0,0,       0,0,  1,0, 0,11,32'hB0,      32'h200));

        do_reset();
        chk("reset WrEn_RF", wen, 1'b0);
        chk("reset WAddr_RF", waddr, 5'd0);
        chk("reset WD_RF", wd, 32'd0);
        chk("reset pend", pend, 32'd0);
        chk("reset ld_ready", ld_ready, 1'b1);
        chk("reset stall_req", stall, 1'b0);

        for (int i = 0; i < tbl.size(); i++) begin
            alu_valid = tbl[i].av; alu_rd = tbl[i].ard; alu_data = tbl[i].adat;
            ld_valid = tbl[i].lv; ld_rd = tbl[i].lrd; ld_data = tbl[i].ldat;
            issue_valid = tbl[i].iv; issue_rd = tbl[i].ird;
            #1;
            chk($sformatf("row%0d ld_ready", i), ld_ready, tbl[i].e_rdy);
            chk($sformatf("row%0d stall_req", i), stall, tbl[i].e_stall);
            @(posedge clk);
            #1;
            chk($sformatf("row%0d WrEn_RF", i), wen, tbl[i].e_wen);
            chk($sformatf("row%0d WAddr_RF", i), waddr, tbl[i].e_addr);
            chk($sformatf("row%0d WD_RF", i), wd, tbl[i].e_wd);
            chk($sformatf("row%0d pend", i), pend, tbl[i].e_pend);
        end
        idle_inputs();

        // ---- reset with two queued loads and pend = 0x84 ----
        do_reset();
        issue_valid = 1'b1; issue_rd = 5'd2;
        @(posedge clk); #1;
        issue_rd = 5'd7;
        @(posedge clk); #1;
        issue_valid = 1'b0;
        alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 32'h1234_5678;
        ld_valid = 1'b1; ld_rd = 5'd12; ld_data = 32'hC0;
        @(posedge clk); #1;
        ld_rd = 5'd13; ld_data = 32'hD0;
        @(posedge clk); #1;
        ld_valid = 1'b0;
        chk("pre-reset pend", pend, 32'h84);
        chk("pre-reset stall_req", stall, 1'b1);
        chk("pre-reset WD_RF", wd, 32'h1234_5678);
        idle_inputs();
        #2 rst_n = 1'b0;
        #1;
        chk("async WrEn_RF", wen, 1'b0);
        chk("async WAddr_RF", waddr, 5'd0);
        chk("async WD_RF", wd, 32'd0);
        chk("async pend", pend, 32'd0);
        chk("async ld_ready", ld_ready, 1'b1);
        chk("async stall_req", stall, 1'b0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post-release WrEn_RF", wen, 1'b0);
        @(posedge clk); #1;
        chk("post-release WrEn_RF 2", wen, 1'b0);
        chk("post-release ld_ready", ld_ready, 1'b1);

        // ---- randomized run against the model ----
        do_reset();
        model_reset();
        for (int c = 0; c < 400; c++) begin
            alu_valid   = ($urandom_range(0, 99) < 45);
            alu_rd      = 5'($urandom_range(0, 7));
            alu_data    = $urandom;
            ld_valid    = ($urandom_range(0, 99) < 55);
            ld_rd       = 5'($urandom_range(0, 7));
            ld_data     = $urandom;
            issue_valid = ($urandom_range(0, 99) < 40);
            issue_rd    = 5'($urandom_range(0, 7));
            #1;
            model_step();
        end
        idle_inputs();
        #1;
        for (int c = 0; c < 4; c++) model_step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/rf_writeback.md
RF_WRITEBACK -- requirements
Module: rf_writeback

Interface
REQ-001 Parameter: XLEN, 32, data width of register write port.
REQ-002 Parameter: LQ_DEPTH, 2, load-result queue entries (power of two, >=2).
REQ-003 clk  in  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 alu_valid  in  1  ALU result present this cycle; never back-pressured.
REQ-006 alu_rd  in  5  ALU destination register.
REQ-007 alu_data  in  XLEN  ALU result.
REQ-008 ld_valid  in  1  load result offered.
REQ-009 ld_ready  out  1  load result accepted when ld_valid&ld_ready.
REQ-010 ld_rd  in  5  load destination register.
REQ-011 ld_data  in  XLEN  load data.
REQ-012 issue_valid  in  1  decode issues instruction writing issue_rd.
REQ-013 issue_rd  in  5  destination being marked pending.
REQ-014 WrEn_RF  out  1  register-file write enable (registered).
REQ-015 WAddr_RF  out  5  register-file write address (registered).
REQ-016 WD_RF  out  XLEN  register-file write data (registered).
REQ-017 pend  out  32  scoreboard; bit n = write to xn outstanding.
REQ-018 stall_req  out  1  queue full; pipeline must not deliver a new ALU result that would collide with a queued load next cycle.

Function
REQ-019 Each cycle at most one write SHALL be presented on the register-file port.
REQ-020 Priority: valid ALU result with alu_rd!=0 wins; otherwise queue head (if non-empty) is written and popped.
REQ-021 ALU write SHALL appear on WrEn_RF/WAddr_RF/WD_RF exactly 1 cycle after alu_valid.
REQ-022 Accepted load SHALL be pushed into the queue; a load accepted into an empty queue with no ALU write that cycle SHALL still take one cycle through the queue (write visible 2 cycles after acceptance).
REQ-023 ld_ready = queue not full; push and pop in the same cycle on a full queue SHALL NOT be permitted (ld_ready low when full, regardless of pop).
REQ-024 Writes to x0 (alu_rd==0 or ld_rd==0) SHALL be discarded: load still handshaken, nothing queued, WrEn_RF stays low.
REQ-025 Queue SHALL be FIFO; pointers wrap modulo LQ_DEPTH; count 0..LQ_DEPTH.
REQ-026 stall_req = queue count == LQ_DEPTH.
REQ-027 pend[n] set on issue_valid with issue_rd==n, n!=0; cleared in the cycle WrEn_RF=1 with WAddr_RF==n.
REQ-028 Simultaneous set and clear of same bit: set wins (bit stays 1).
REQ-029 pend[0] SHALL be constant 0.
REQ-030 When no write is selected, WrEn_RF=0 and WAddr_RF/WD_RF hold previous values.

Reset
REQ-031 On rst_n low (asynchronously): WrEn_RF=0, WAddr_RF=0, WD_RF=0, pend=0, queue empty (ld_ready=1, stall_req=0).
REQ-032 Reset mid-operation SHALL discard all queued loads and pending bits; no write issued in the first cycle after release.

Structure
REQ-033 Shared package rf_pkg SHALL hold XLEN, NREG=32, REG_ADDR_W=5 and the x0 index constant.
REQ-034 Load queue SHALL be a separate sub-module wb_fifo (sync FIFO, push/pop, full/empty, count).

Verification
REQ-035 ALU only: alu_valid, rd=5, data=0xDEADBEEF -> next cycle WrEn_RF=1, WAddr_RF=5, WD_RF=0xDEADBEEF; pend[5] clears.
REQ-036 Contention: ALU rd=3 and load rd=7 same cycle -> x3 written at cycle+1, x7 at cycle+2.
REQ-037 Back-pressure: ALU every cycle, 3 loads offered -> ld_ready low after 2 accepted, stall_req=1; loads retire in order once ALU idles.
REQ-038 x0: alu_rd=0 and ld_rd=0 -> no WrEn_RF pulse, ld handshake completes, pend unchanged.
REQ-039 Scoreboard race: issue_rd=9 same cycle as write to x9 -> pend[9] remains 1.
REQ-040 Reset: assert rst_n low with 2 queued loads and pend=0x0000_0084 -> all outputs zero, ld_ready=1, no write after release.
